// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the binary-to-BCD converter
package bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int          DIGIT_W     = 4;
  localparam logic [3:0]  ADD3_THRESH = 4'd5;
  localparam logic [3:0]  BCD_NINE    = 4'h9;
  localparam logic [26:0] MAX_DEC_8   = 27'd99_999_999;

  // Largest value representable in 'digits' decimal digits (10^digits - 1).
  function automatic logic [63:0] max_dec(input int digits);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < digits; i++) begin
      r = r * 64'd10 + 64'd9;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// rtl/bcd_add3_digit.sv - combinational double-dabble cell: add 3 to a digit >= 5
module bcd_add3_digit
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adj
);

  assign adj = (digit >= ADD3_THRESH) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary to packed BCD, optional BIN_TO_BCD_AUTO_REFRESH_EN
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 27,
  parameter int DIGITS = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                START,
  input  logic [BIN_W-1:0]    BIN,
  output logic                BUSY,
  output logic                DONE,
  output logic [DIGITS*4-1:0] BCD,
  output logic                OVF
);

  localparam int BCD_W  = DIGITS * DIGIT_W;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);
  localparam logic [63:0]      MAX_DEC   = max_dec(DIGITS);

  state_t            state;
  state_t            state_nxt;
  logic [WORK_W-1:0] work;
  logic [WORK_W-1:0] work_shift;
  logic [BCD_W-1:0]  adj;
  logic [CNT_W-1:0]  cnt;
  logic              ovf_pend;
  logic              ovf_cmp;
  logic              go;
  logic              last;

`ifdef BIN_TO_BCD_AUTO_REFRESH_EN
  assign go = START | 1'b1;
`else
  assign go = START;
`endif

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_add3_digit u_digit (
        .digit (work[BIN_W + g*DIGIT_W +: DIGIT_W]),
        .adj   (adj[g*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  // Adjusted digits and the remaining binary bits move left together.
  assign work_shift = {adj[BCD_W-2:0], work[BIN_W-1:0], 1'b0};
  assign last       = (cnt == LAST_ITER);
  assign ovf_cmp    = ({{(64-BIN_W){1'b0}}, BIN} > MAX_DEC);
  assign BUSY       = (state == SHIFT);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go)   state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // BCD/OVF are only written on the final iteration so the display never sees partial results.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      work     <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      BCD      <= '0;
      OVF      <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            work     <= {{BCD_W{1'b0}}, BIN};
            ovf_pend <= ovf_cmp;
            cnt      <= '0;
          end
        end
        SHIFT: begin
          work <= work_shift;
          cnt  <= cnt + CNT_W'(1);
          if (last) begin
            BCD  <= ovf_pend ? {DIGITS{BCD_NINE}} : work_shift[WORK_W-1 -: BCD_W];
            OVF  <= ovf_pend;
            DONE <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        START;
  logic [26:0] BIN;
  logic        BUSY;
  logic        DONE;
  logic [31:0] BCD;
  logic        OVF;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [26:0] bin;
    logic [31:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs [9];

  bin_to_bcd_seq #(.BIN_W(27), .DIGITS(8)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .BIN   (BIN),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .BCD   (BCD),
    .OVF   (OVF)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: decimal digits by division; saturate to all nines when out of range.
  function automatic logic [32:0] ref_model(input logic [26:0] b);
    int unsigned v;
    logic [31:0] r;
    v = b;
    r = '0;
    if (v >= 32'd100_000_000) return {1'b1, 32'h9999_9999};
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return {1'b0, r};
  endfunction

  task automatic run_conv(input logic [26:0] b, output int lat, output int busy_n, output logic done_once);
    BIN   = b;
    START = 1'b1;
    @(posedge CLK); #1;
    START  = 1'b0;
    lat    = 0;
    busy_n = 0;
    while (lat < 60) begin
      if (BUSY) busy_n++;
      @(posedge CLK); #1;
      lat++;
      if (DONE) break;
    end
    done_once = DONE;
    @(posedge CLK); #1;
    done_once = done_once & ~DONE;
  endtask

  task automatic conv_and_check(input string tag, input logic [26:0] b, input logic [31:0] eb, input logic eo);
    int   lat;
    int   busy_n;
    logic done_once;
    run_conv(b, lat, busy_n, done_once);
    check({tag, " latency"}, 64'(lat), 64'd27);
    check({tag, " busy_cycles"}, 64'(busy_n), 64'd27);
    check({tag, " done_pulse"}, 64'(done_once), 64'd1);
    check({tag, " bcd"}, 64'(BCD), 64'(eb));
    check({tag, " ovf"}, 64'(OVF), 64'(eo));
  endtask

  initial begin
    logic [32:0] exp_r;
    logic [26:0] rb;
    logic [31:0] prev_bcd;
    int          dones;

    vecs[0] = '{27'd12345678,  32'h1234_5678, 1'b0};
    vecs[1] = '{27'd0,         32'h0000_0000, 1'b0};
    vecs[2] = '{27'd99999999,  32'h9999_9999, 1'b0};
    vecs[3] = '{27'd100000000, 32'h9999_9999, 1'b1};
    vecs[4] = '{27'h7FF_FFFF,  32'h9999_9999, 1'b1};
    vecs[5] = '{27'd5,         32'h0000_0005, 1'b0};
    vecs[6] = '{27'd9,         32'h0000_0009, 1'b0};
    vecs[7] = '{27'd10,        32'h0000_0010, 1'b0};
    vecs[8] = '{27'd1000000,   32'h0100_0000, 1'b0};

    RST_N = 1'b0;
    START = 1'b0;
    BIN   = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset busy", 64'(BUSY), 64'd0);
    check("reset done", 64'(DONE), 64'd0);
    check("reset bcd",  64'(BCD),  64'd0);
    check("reset ovf",  64'(OVF),  64'd0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

`ifdef BIN_TO_BCD_AUTO_REFRESH_EN
    begin
      int          t_done [4];
      logic [31:0] b_done [4];
      int          nd;
      BIN = 27'd9;
      nd  = 0;
      for (int c = 0; c < 200 && nd < 4; c++) begin
        @(posedge CLK); #1;
        if (DONE) begin
          t_done[nd] = c;
          b_done[nd] = BCD;
          nd++;
          BIN = 27'd10;
        end
      end
      check("auto done_count", 64'(nd), 64'd4);
      if (nd == 4) begin
        for (int i = 1; i < 4; i++) check("auto period", 64'(t_done[i] - t_done[i-1]), 64'd28);
        check("auto bcd first",  64'(b_done[0]), 64'h0000_0009);
        check("auto bcd second", 64'(b_done[1]), 64'h0000_0010);
      end
    end
`else
    for (int i = 0; i < 9; i++) begin
      conv_and_check($sformatf("vec%0d", i), vecs[i].bin, vecs[i].bcd, vecs[i].ovf);
    end

    for (int i = 0; i < 24; i++) begin
      rb    = ($urandom_range(0, 3) == 0) ? 27'($urandom) : 27'($urandom_range(0, 99_999_999));
      exp_r = ref_model(rb);
      conv_and_check($sformatf("rand%0d", i), rb, exp_r[31:0], exp_r[32]);
    end

    // START pulses while busy must be ignored; BIN changes after capture have no effect.
    prev_bcd = BCD;
    BIN      = 27'd12345;
    START    = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    dones = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge CLK); #1;
      if (DONE) dones++;
      if (c == 5) check("ignore bcd_held", 64'(BCD), 64'(prev_bcd));
      START = (c == 3 || c == 10);
      if (c == 3) BIN = 27'd42;
    end
    check("ignore done_count", 64'(dones), 64'd1);
    check("ignore bcd", 64'(BCD), 64'h0001_2345);
    check("ignore busy_idle", 64'(BUSY), 64'd0);

    // Asynchronous reset in the middle of a conversion.
    BIN   = 27'd87654321;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (12) @(posedge CLK);
    #1;
    check("midrst busy_before", 64'(BUSY), 64'd1);
    RST_N = 1'b0;
    #1;
    check("midrst busy", 64'(BUSY), 64'd0);
    check("midrst bcd",  64'(BCD),  64'd0);
    check("midrst done", 64'(DONE), 64'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (DONE) dones++;
    end
    check("midrst no_done", 64'(dones), 64'd0);
    conv_and_check("after_rst", 27'd87654321, 32'h8765_4321, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
